tmds_word_aligner: RTL and testbench
====================================

TMDS_WORD_ALIGNER -- requirements
Module: tmds_word_aligner

Interface
REQ-001 INV_TMDS, default 1'b0: when 1, invert every raw_in bit before any other processing, undoing a swapped LVDS +/- pair.
REQ-002 LOCK_COUNT, default 8, legal range 1..12: number of consecutive control-token hits needed to lock.
REQ-003 SEARCH_TIMEOUT, default 4096, legal range 16..65535: cycles without any token before the aligner advances the offset (in SEARCH) or drops lock (in LOCKED).
REQ-004 clk_pixel  input  1  pixel-rate clock; the only clock.
REQ-005 reset_n  input  1  reset, synchronous to clk_pixel, active-low.
REQ-006 raw_in  input  10  unaligned deserialized TMDS bits, one word per cycle; raw_in[0] is the earliest-received bit.
REQ-007 tmds_out  output  10  aligned TMDS symbol, bit0 first in time, as fed to a TMDS decoder.
REQ-008 tmds_locked  output  1  word alignment established.
REQ-009 tmds_offset  output  4  current bit-slip offset, 0..9.
REQ-010 ctrl_token  output  1  tmds_out currently holds a control token.
REQ-011 ctrl_code  output  2  {C1,C0} decoded from the token; 0 when ctrl_token=0.

Function
REQ-012 One register, raw_prev, holds the previous (post-INV) raw_in; window[19:0] = {raw_in_post_inv, raw_prev}; candidate = window[offset+9:offset].
REQ-013 Token match (values written bit9..bit0): 1101010100 -> code 00; 0010101011 -> code 01; 0101010100 -> code 10; 1010101011 -> code 11; any other value is a non-token.
REQ-014 All outputs are registered; tmds_out, ctrl_token and ctrl_code reflect the candidate evaluated on the previous edge (1-cycle latency from the raw_in word that completes the symbol).
REQ-015 State machine: SEARCH, LOCKED; tmds_locked = (state==LOCKED).
REQ-016 SEARCH: a candidate token increments hit_cnt and clears timer; a non-token clears hit_cnt and increments timer.
REQ-017 SEARCH: when a hit makes hit_cnt reach LOCK_COUNT, go to LOCKED on that edge; tmds_locked is visible alongside tmds_out carrying that token.
REQ-018 SEARCH: when timer reaches SEARCH_TIMEOUT, advance offset (9 wraps to 0) and clear hit_cnt and timer on that edge.
REQ-019 LOCKED: a token clears timer; a non-token increments timer; offset is frozen; hit_cnt is ignored.
REQ-020 LOCKED: when timer reaches SEARCH_TIMEOUT, go to SEARCH with offset unchanged, hit_cnt and timer cleared; tmds_locked falls on that edge.
REQ-021 While state is SEARCH (including the loss edge), tmds_out = 0, ctrl_token = 0 and ctrl_code = 0; tmds_offset always shows the live offset.
REQ-022 Simultaneous events: a token hit takes precedence over timeout, because a hit clears timer that cycle; lock and advance can never both occur on one edge.
REQ-023 After an offset advance, the first candidate at the new offset is evaluated on the next cycle, with no blanking cycle.
REQ-024 Counter widths: timer is $clog2(SEARCH_TIMEOUT+1) bits; hit_cnt is 4 bits; neither counter wraps.

Reset
REQ-025 When reset_n=0 at a clk_pixel edge: state=SEARCH, offset=0, hit_cnt=0, timer=0, raw_prev=0, and all outputs 0; this takes effect on the edge regardless of state, including mid-lock.

Verification (bench uses LOCK_COUNT=8, SEARCH_TIMEOUT=64)
REQ-026 Aligned stream of 12 x 1101010100 followed by data: tmds_locked rises with the 8th token on tmds_out; tmds_offset=0; ctrl_code=00; ctrl_token=1 for tokens 8-12, then 0.
REQ-027 Bit stream delayed so each symbol starts at bit 3 of raw_prev, repeating 12 x 0101010100 plus 200 data words per line: offset steps 0->1->2->3 at 64-cycle timeouts; lock occurs at offset 3 with ctrl_code=10.
REQ-028 Locked, then 64 consecutive non-token words: tmds_locked and tmds_out drop to 0 on the 64th edge; tmds_offset stays 3; relock occurs after the next 8 tokens.
REQ-029 In SEARCH, 7 tokens, 1 non-token, then 8 tokens: no lock after the first 7; lock occurs with the 8th token after the break.
REQ-030 INV_TMDS=1 with the bit-inverted stream from REQ-026: identical outputs to REQ-026; reset_n=0 while locked sets all outputs to 0 and offset to 0 on the next edge.

Source files
------------

// File: rtl/tmds_word_aligner_if.sv
// Bus between a deserializer-side source and the TMDS word aligner.
// The master drives unaligned raw words and the slave returns the aligned symbol and lock status.
interface tmds_word_aligner_if;
   logic [9:0] raw_in;
   logic [9:0] tmds_out;
   logic       tmds_locked;
   logic [3:0] tmds_offset;
   logic       ctrl_token;
   logic [1:0] ctrl_code;

   modport master (
      output raw_in,
      input  tmds_out,
      input  tmds_locked,
      input  tmds_offset,
      input  ctrl_token,
      input  ctrl_code
   );

   modport slave (
      input  raw_in,
      output tmds_out,
      output tmds_locked,
      output tmds_offset,
      output ctrl_token,
      output ctrl_code
   );
endinterface

// File: rtl/tmds_word_aligner.sv
// Finds the 10-bit symbol boundary in a deserialized TMDS stream by hunting for control tokens,
// slipping one bit at a time on timeout and dropping lock when tokens stop arriving.
module tmds_word_aligner #(
   parameter logic INV_TMDS       = 1'b0,
   parameter int   LOCK_COUNT     = 8,
   parameter int   SEARCH_TIMEOUT = 4096
) (
   input  logic               clk_pixel,
   input  logic               reset_n,
   tmds_word_aligner_if.slave bus
);
   localparam int TW = $clog2(SEARCH_TIMEOUT + 1);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t        state;
   logic [3:0]    offset;
   logic [3:0]    hit_cnt;
   logic [TW-1:0] timer;
   logic [9:0]    raw_prev;
   logic [9:0]    tmds_q;
   logic          token_q;
   logic [1:0]    code_q;

   logic [9:0]    raw_post;
   logic [18:0]   window;
   logic [9:0]    candidate;
   logic          is_token;
   logic [1:0]    code;
   logic [3:0]    hit_inc;
   logic [TW-1:0] timer_inc;
   logic          lock_hit;
   logic          timeout;

   assign raw_post  = bus.raw_in ^ {10{INV_TMDS}};
   // The top raw bit only ever feeds raw_prev, since offset never exceeds 9.
   assign window    = {raw_post[8:0], raw_prev};
   assign hit_inc   = hit_cnt + 4'd1;
   assign timer_inc = timer + TW'(1);
   assign lock_hit  = (hit_inc == 4'(LOCK_COUNT));
   assign timeout   = (timer_inc == TW'(SEARCH_TIMEOUT));

   always_comb begin
      candidate = window[9:0];
      case (offset)
         4'd1:    candidate = window[10:1];
         4'd2:    candidate = window[11:2];
         4'd3:    candidate = window[12:3];
         4'd4:    candidate = window[13:4];
         4'd5:    candidate = window[14:5];
         4'd6:    candidate = window[15:6];
         4'd7:    candidate = window[16:7];
         4'd8:    candidate = window[17:8];
         4'd9:    candidate = window[18:9];
         default: candidate = window[9:0];
      endcase
   end

   always_comb begin
      is_token = 1'b1;
      code     = 2'b00;
      case (candidate)
         10'b1101010100: code = 2'b00;
         10'b0010101011: code = 2'b01;
         10'b0101010100: code = 2'b10;
         10'b1010101011: code = 2'b11;
         default:        is_token = 1'b0;
      endcase
   end

   // A hit clears the timer in the same cycle, so lock and slip can never coincide.
   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         state    <= SEARCH;
         offset   <= 4'd0;
         hit_cnt  <= 4'd0;
         timer    <= '0;
         raw_prev <= 10'd0;
         tmds_q   <= 10'd0;
         token_q  <= 1'b0;
         code_q   <= 2'b00;
      end else begin
         raw_prev <= raw_post;
         tmds_q   <= 10'd0;
         token_q  <= 1'b0;
         code_q   <= 2'b00;
         case (state)
            SEARCH: begin
               if (is_token) begin
                  timer   <= '0;
                  hit_cnt <= hit_inc;
                  if (lock_hit) begin
                     state   <= LOCKED;
                     tmds_q  <= candidate;
                     token_q <= 1'b1;
                     code_q  <= code;
                  end
               end else begin
                  hit_cnt <= 4'd0;
                  if (timeout) begin
                     timer  <= '0;
                     offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                  end else begin
                     timer <= timer_inc;
                  end
               end
            end
            LOCKED: begin
               if (is_token) begin
                  timer   <= '0;
                  tmds_q  <= candidate;
                  token_q <= 1'b1;
                  code_q  <= code;
               end else if (timeout) begin
                  state   <= SEARCH;
                  hit_cnt <= 4'd0;
                  timer   <= '0;
               end else begin
                  timer  <= timer_inc;
                  tmds_q <= candidate;
               end
            end
         endcase
      end
   end

   assign bus.tmds_out    = tmds_q;
   assign bus.tmds_locked = (state == LOCKED);
   assign bus.tmds_offset = offset;
   assign bus.ctrl_token  = token_q;
   assign bus.ctrl_code   = code_q;
endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: a normal and an inverted-input instance see the same
// logical stream and must produce identical outputs.
module tb_tmds_word_aligner;
   localparam logic [9:0] TOK00 = 10'b1101010100;
   localparam logic [9:0] TOK01 = 10'b0010101011;
   localparam logic [9:0] TOK10 = 10'b0101010100;
   localparam logic [9:0] TOK11 = 10'b1010101011;

   typedef struct {
      logic [9:0] raw;
      logic [9:0] tmds;
      logic       locked;
      logic [3:0] off;
      logic       tok;
      logic [1:0] code;
   } vec_t;

   logic       clk_pixel = 1'b0;
   logic       reset_n   = 1'b0;
   logic [9:0] prev_sym  = 10'd0;
   int         checks    = 0;
   int         errors    = 0;
   vec_t       vecs [15];
   logic [9:0] seq29 [19];

   tmds_word_aligner_if bus_n ();
   tmds_word_aligner_if bus_i ();

   tmds_word_aligner #(.INV_TMDS(1'b0), .LOCK_COUNT(8), .SEARCH_TIMEOUT(64)) dut_n (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .bus       (bus_n.slave)
   );

   tmds_word_aligner #(.INV_TMDS(1'b1), .LOCK_COUNT(8), .SEARCH_TIMEOUT(64)) dut_i (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .bus       (bus_i.slave)
   );

   always #5 clk_pixel = ~clk_pixel;

   task automatic applyStimulus(input logic [9:0] w);
      @(negedge clk_pixel);
      bus_n.raw_in = w;
      bus_i.raw_in = ~w;
      @(posedge clk_pixel);
      #1;
   endtask

   // Shifts symbols onto the wire so each one starts at bit 3 of the previous word.
   task automatic sendSym(input logic [9:0] s);
      applyStimulus({s[6:0], prev_sym[9:7]});
      prev_sym = s;
   endtask

   task automatic compareOne(input string name, input string tag, input logic [17:0] act, input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s (%s): got tmds=%h locked=%b off=%0d tok=%b code=%b, want tmds=%h locked=%b off=%0d tok=%b code=%b",
                  name, tag, act[17:8], act[7], act[6:3], act[2], act[1:0],
                  exp[17:8], exp[7], exp[6:3], exp[2], exp[1:0]);
      end
   endtask

   task automatic checkOutput(input string name, input logic [9:0] tmds, input logic locked,
                              input logic [3:0] off, input logic tok, input logic [1:0] code);
      compareOne(name, "norm", {bus_n.tmds_out, bus_n.tmds_locked, bus_n.tmds_offset, bus_n.ctrl_token, bus_n.ctrl_code},
                 {tmds, locked, off, tok, code});
      compareOne(name, "inv", {bus_i.tmds_out, bus_i.tmds_locked, bus_i.tmds_offset, bus_i.ctrl_token, bus_i.ctrl_code},
                 {tmds, locked, off, tok, code});
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      applyStimulus(10'd0);
      applyStimulus(10'd0);
      reset_n  = 1'b1;
      prev_sym = 10'd0;
   endtask

   initial begin
      bus_n.raw_in = 10'd0;
      bus_i.raw_in = 10'h3FF;

      // Aligned stream at offset 0: the candidate on edge n is the word sent at edge n-1.
      vecs[0]  = '{TOK00,  10'd0,  1'b0, 4'd0, 1'b0, 2'b00};
      vecs[1]  = '{TOK00,  10'd0,  1'b0, 4'd0, 1'b0, 2'b00};
      vecs[2]  = '{TOK00,  10'd0,  1'b0, 4'd0, 1'b0, 2'b00};
      vecs[3]  = '{TOK00,  10'd0,  1'b0, 4'd0, 1'b0, 2'b00};
      vecs[4]  = '{TOK00,  10'd0,  1'b0, 4'd0, 1'b0, 2'b00};
      vecs[5]  = '{TOK00,  10'd0,  1'b0, 4'd0, 1'b0, 2'b00};
      vecs[6]  = '{TOK00,  10'd0,  1'b0, 4'd0, 1'b0, 2'b00};
      vecs[7]  = '{TOK00,  10'd0,  1'b0, 4'd0, 1'b0, 2'b00};
      vecs[8]  = '{TOK00,  TOK00,  1'b1, 4'd0, 1'b1, 2'b00};
      vecs[9]  = '{TOK00,  TOK00,  1'b1, 4'd0, 1'b1, 2'b00};
      vecs[10] = '{TOK00,  TOK00,  1'b1, 4'd0, 1'b1, 2'b00};
      vecs[11] = '{TOK00,  TOK00,  1'b1, 4'd0, 1'b1, 2'b00};
      vecs[12] = '{10'h1F0, TOK00, 1'b1, 4'd0, 1'b1, 2'b00};
      vecs[13] = '{10'h00F, 10'h1F0, 1'b1, 4'd0, 1'b0, 2'b00};
      vecs[14] = '{10'h3C3, 10'h00F, 1'b1, 4'd0, 1'b0, 2'b00};

      for (int i = 0; i < 19; i++) seq29[i] = TOK11;
      seq29[7]  = 10'h1F0;
      seq29[16] = TOK01;
      seq29[17] = 10'h1F0;
      seq29[18] = 10'h000;

      doReset();
      checkOutput("reset_state", 10'd0, 1'b0, 4'd0, 1'b0, 2'b00);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].raw);
         checkOutput($sformatf("aligned_vec%0d", i), vecs[i].tmds, vecs[i].locked, vecs[i].off, vecs[i].tok, vecs[i].code);
      end

      // Reset while locked, with a token on the input, must still clear everything.
      reset_n = 1'b0;
      applyStimulus(TOK00);
      checkOutput("reset_mid_lock", 10'd0, 1'b0, 4'd0, 1'b0, 2'b00);
      reset_n  = 1'b1;
      prev_sym = 10'd0;

      // Seven tokens, a break, then eight tokens: only the second run locks.
      for (int n = 0; n < 19; n++) begin
         applyStimulus(seq29[n]);
         case (n)
            7:  checkOutput("seven_hits_no_lock", 10'd0, 1'b0, 4'd0, 1'b0, 2'b00);
            8:  checkOutput("break_clears_hits", 10'd0, 1'b0, 4'd0, 1'b0, 2'b00);
            15: checkOutput("seven_after_break", 10'd0, 1'b0, 4'd0, 1'b0, 2'b00);
            16: checkOutput("lock_after_break", TOK11, 1'b1, 4'd0, 1'b1, 2'b11);
            17: checkOutput("code01_locked", TOK01, 1'b1, 4'd0, 1'b1, 2'b01);
            18: checkOutput("data_locked", 10'h1F0, 1'b1, 4'd0, 1'b0, 2'b00);
            default: ;
         endcase
      end

      // Symbols start at bit 3: three timeouts slip the offset before the line tokens lock.
      doReset();
      for (int n = 0; n <= 220; n++) begin
         sendSym(((n % 212) < 12) ? TOK10 : 10'h000);
         case (n)
            62:  checkOutput("off0_before_timeout", 10'd0, 1'b0, 4'd0, 1'b0, 2'b00);
            63:  checkOutput("off1_at_timeout", 10'd0, 1'b0, 4'd1, 1'b0, 2'b00);
            126: checkOutput("off1_hold", 10'd0, 1'b0, 4'd1, 1'b0, 2'b00);
            127: checkOutput("off2_at_timeout", 10'd0, 1'b0, 4'd2, 1'b0, 2'b00);
            190: checkOutput("off2_hold", 10'd0, 1'b0, 4'd2, 1'b0, 2'b00);
            191: checkOutput("off3_at_timeout", 10'd0, 1'b0, 4'd3, 1'b0, 2'b00);
            219: checkOutput("off3_seven_hits", 10'd0, 1'b0, 4'd3, 1'b0, 2'b00);
            220: checkOutput("lock_off3", TOK10, 1'b1, 4'd3, 1'b1, 2'b10);
            default: ;
         endcase
      end

      // Sixty-four non-token symbols after the last token drop lock on the 64th edge.
      for (int n = 221; n <= 285; n++) begin
         sendSym(10'h3C3);
         case (n)
            221: checkOutput("locked_last_token", TOK10, 1'b1, 4'd3, 1'b1, 2'b10);
            284: checkOutput("locked_63_misses", 10'h3C3, 1'b1, 4'd3, 1'b0, 2'b00);
            285: checkOutput("lock_lost_64", 10'd0, 1'b0, 4'd3, 1'b0, 2'b00);
            default: ;
         endcase
      end

      for (int n = 286; n <= 294; n++) begin
         sendSym(TOK10);
         case (n)
            293: checkOutput("relock_seven_hits", 10'd0, 1'b0, 4'd3, 1'b0, 2'b00);
            294: checkOutput("relock_eighth", TOK10, 1'b1, 4'd3, 1'b1, 2'b10);
            default: ;
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
